// File: rtl/miner_pkg.sv
// Shared miner constants: FSM state encoding and block-header geometry.
package miner_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RECV  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int HEADER_BYTES = 80;
  localparam int HEADER_WORDS = 20;

endpackage

// File: rtl/header_loader_if.sv
// Byte-stream input and RAM write port of the header loader, bundled as one interface.
interface header_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic [7:0]               byte_in;
  logic                     byte_valid;
  logic                     byte_ready;
  logic                     ram_wEn;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_data;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, ram_wEn, ram_addr, ram_data
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, ram_wEn, ram_addr, ram_data
  );
endinterface

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: first byte of a word ends up in the top byte lane.
module byte_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [7:0]            byte_in,
  output logic                  word_full,
  output logic [DATA_WIDTH-1:0] word
);
  localparam int BPW   = DATA_WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BPW - 1);

  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] pack_q, pack_d;

  // word is the value including the byte being shifted in now, so the
  // loader can register it on the same edge that accepts the last byte.
  assign word      = (pack_q << 8) | DATA_WIDTH'(byte_in);
  assign word_full = shift && (byte_idx_q == LAST);

  always_comb begin
    pack_d     = pack_q;
    byte_idx_d = byte_idx_q;
    if (clear) begin
      pack_d     = '0;
      byte_idx_d = '0;
    end else if (shift) begin
      pack_d     = word;
      byte_idx_d = word_full ? '0 : byte_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      pack_q     <= pack_d;
      byte_idx_q <= byte_idx_d;
    end
  end
endmodule

// File: rtl/header_loader.sv
// Loads WORDS big-endian packed words from a byte stream into RAM at BASE_ADDR.
// Optional trailing XOR checksum byte: define HEADER_LOADER_CHECKSUM_EN.
module header_loader
  import miner_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int BASE_ADDR     = 0,
  parameter int WORDS         = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  header_loader_if.slave  bus,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam logic [ADDRESS_WIDTH-1:0] BASE     = ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(WORDS - 1);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]    ram_data_q, ram_data_d;
  logic                     ram_wen_q, ram_wen_d;
  logic                     done_q, done_d;
  logic                     byte_ready;
  logic                     pk_clear, pk_shift, word_full;
  logic [DATA_WIDTH-1:0]    word;
`ifdef HEADER_LOADER_CHECKSUM_EN
  logic                     err_q, err_d;
  logic [7:0]               xor_q, xor_d;
`endif

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .shift     (pk_shift),
    .byte_in   (bus.byte_in),
    .word_full (word_full),
    .word      (word)
  );

  always_comb begin
    byte_ready = (state_q == ST_RECV);
`ifdef HEADER_LOADER_CHECKSUM_EN
    if (state_q == ST_CHECK) byte_ready = 1'b1;
`endif
  end

  assign pk_shift = bus.byte_valid && byte_ready && (state_q == ST_RECV);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wen_d  = 1'b0;
    done_d     = done_q;
    pk_clear   = 1'b0;
`ifdef HEADER_LOADER_CHECKSUM_EN
    err_d      = err_q;
    xor_d      = xor_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RECV;
          word_idx_d = '0;
          pk_clear   = 1'b1;
          done_d     = 1'b0;
`ifdef HEADER_LOADER_CHECKSUM_EN
          err_d      = 1'b0;
          xor_d      = '0;
`endif
        end
      end
      ST_RECV: begin
`ifdef HEADER_LOADER_CHECKSUM_EN
        if (pk_shift) xor_d = xor_q ^ bus.byte_in;
`endif
        // Address/data are registered here so they are stable from the
        // start of the WRITE cycle, ahead of the RAM's falling-edge capture.
        if (word_full) begin
          state_d    = ST_WRITE;
          ram_wen_d  = 1'b1;
          ram_addr_d = BASE + word_idx_q;
          ram_data_d = word;
        end
      end
      ST_WRITE: begin
        if (word_idx_q == LAST_IDX) begin
`ifdef HEADER_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = ST_RECV;
        end
      end
`ifdef HEADER_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (bus.byte_valid) begin
          err_d   = (bus.byte_in != xor_q);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      ram_addr_q <= BASE;
      ram_data_q <= '0;
      ram_wen_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef HEADER_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wen_q  <= ram_wen_d;
      done_q     <= done_d;
`ifdef HEADER_LOADER_CHECKSUM_EN
      err_q      <= err_d;
      xor_q      <= xor_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.ram_wEn    = ram_wen_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_data   = ram_data_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = done_q;
`ifdef HEADER_LOADER_CHECKSUM_EN
  assign err            = err_q;
`else
  assign err            = 1'b0;
`endif
endmodule

// File: tb/tb_header_loader.sv
// Bench for header_loader: three instances (20 words @0, 2 words @0x100, 1 word @0)
// share one stimulus driver; sel picks which instance is checked.
module tb_header_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  int          sel = 0;
  int          cur_base = 0;
  int          cur_words = 20;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  tx_q[$];
  logic [43:0] wr_log[$];
  int          log0 = 0;

  always #5 clk = ~clk;

  header_loader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) bus_a ();
  header_loader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) bus_b ();
  header_loader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) bus_c ();
  logic busy_a, done_a, err_a, busy_b, done_b, err_b, busy_c, done_c, err_c;

  assign bus_a.byte_in = byte_in;  assign bus_a.byte_valid = byte_valid;
  assign bus_b.byte_in = byte_in;  assign bus_b.byte_valid = byte_valid;
  assign bus_c.byte_in = byte_in;  assign bus_c.byte_valid = byte_valid;

  header_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR(0), .WORDS(20)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(bus_a), .busy(busy_a), .done(done_a), .err(err_a));
  header_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR(256), .WORDS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(bus_b), .busy(busy_b), .done(done_b), .err(err_b));
  header_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BASE_ADDR(0), .WORDS(1)) dut_c (
    .clk(clk), .reset(reset), .start(start), .bus(bus_c), .busy(busy_c), .done(done_c), .err(err_c));

  logic        rdy_m, wen_m, busy_m, done_m, err_m;
  logic [11:0] addr_m;
  logic [31:0] data_m;

  always_comb begin
    rdy_m = bus_a.byte_ready; wen_m = bus_a.ram_wEn; addr_m = bus_a.ram_addr;
    data_m = bus_a.ram_data; busy_m = busy_a; done_m = done_a; err_m = err_a;
    if (sel == 1) begin
      rdy_m = bus_b.byte_ready; wen_m = bus_b.ram_wEn; addr_m = bus_b.ram_addr;
      data_m = bus_b.ram_data; busy_m = busy_b; done_m = done_b; err_m = err_b;
    end else if (sel == 2) begin
      rdy_m = bus_c.byte_ready; wen_m = bus_c.ram_wEn; addr_m = bus_c.ram_addr;
      data_m = bus_c.ram_data; busy_m = busy_c; done_m = done_c; err_m = err_c;
    end
  end

  // RAM-side view: every falling edge with write enable is one committed word.
  always @(negedge clk) begin
    if (wen_m) wr_log.push_back({addr_m, data_m});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [31:0] model_word(input int k);
    return (32'(tx_q[4*k]) << 24) | (32'(tx_q[4*k+1]) << 16) |
           (32'(tx_q[4*k+2]) << 8) | 32'(tx_q[4*k+3]);
  endfunction

  task automatic fill_seq(input int n, input int first);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'(first + i));
  endtask

  task automatic fill_rand(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic select(input int s);
    sel = s;
    cur_base  = (s == 1) ? 256 : 0;
    cur_words = (s == 0) ? 20 : (s == 1) ? 2 : 1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_ready", 32'(rdy_m), 0);
    chk("rst_wen", 32'(wen_m), 0);
    chk("rst_addr", 32'(addr_m), 32'(cur_base));
    chk("rst_data", data_m, 0);
    chk("rst_busy", 32'(busy_m), 0);
    chk("rst_done", 32'(done_m), 0);
    chk("rst_err", 32'(err_m), 0);
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy_m), 1);
    chk("start_ready", 32'(rdy_m), 1);
    chk("start_done_clr", 32'(done_m), 0);
    chk("start_err_clr", 32'(err_m), 0);
    log0 = wr_log.size();
  endtask

  // Offers tx_q[0..n-1]; valid on one of every `period` cycles, held byte until taken.
  task automatic run_bytes(input int n, input int period, input int pulse_at);
    int  idx = 0;
    int  waited = 0;
    bit  v, rdy, acc, pulsed;
    pulsed = 0;
    while (idx < n) begin
      if (waited > n * period * 3 + 40) begin
        chk("stream_timeout", 32'(idx), 32'(n));
        break;
      end
      v = (waited % period) == 0;
      byte_valid = v;
      byte_in = v ? tx_q[idx] : 8'($urandom);
      start = (idx == pulse_at) && !pulsed;
      if (start) pulsed = 1;
      rdy = rdy_m;
      @(posedge clk); #1;
      waited++;
      start = 1'b0;
      acc = v && rdy;
      if (acc) idx++;
      chk("wen_timing", 32'(wen_m), 32'(acc && (idx % 4 == 0)));
      if (acc && (idx % 4 == 0)) begin
        chk("write_addr", 32'(addr_m), 32'(cur_base + idx / 4 - 1));
        chk("write_data", data_m, model_word(idx / 4 - 1));
        chk("write_ready_low", 32'(rdy_m), 0);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit corrupt);
`ifdef HEADER_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < cur_words * 4; i++) x = x ^ tx_q[i];
    @(posedge clk); #1;
    chk("check_ready", 32'(rdy_m), 1);
    chk("check_not_done", 32'(done_m), 0);
    byte_valid = 1'b1;
    byte_in = corrupt ? (x ^ 8'h01) : x;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("done_set", 32'(done_m), 1);
    chk("err_flag", 32'(err_m), 32'(corrupt));
`else
    @(posedge clk); #1;
    chk("done_set", 32'(done_m), 1);
    chk("err_zero", 32'(err_m), 0);
`endif
    chk("done_busy", 32'(busy_m), 0);
    chk("done_wen", 32'(wen_m), 0);
    chk("done_ready", 32'(rdy_m), 0);
    chk("write_count", 32'(wr_log.size() - log0), 32'(cur_words));
  endtask

  task automatic run_frame(input int period, input int pulse_at, input bit corrupt);
    start_frame();
    run_bytes(cur_words * 4, period, pulse_at);
    finish_frame(corrupt);
  endtask

  initial begin
    logic [43:0] e;
    repeat (2) @(posedge clk);
    #1;

    // Full default header 00..4F, valid held high.
    select(0);
    do_reset();
    fill_seq(80, 0);
    run_frame(1, -1, 0);
    e = wr_log[log0];
    chk("first_word", e[31:0], 32'h00010203);
    chk("first_addr", 32'(e[43:32]), 0);
    e = wr_log[$];
    chk("last_word", e[31:0], 32'h4C4D4E4F);
    chk("last_addr", 32'(e[43:32]), 19);

    // Gapped stream into the two-word instance at 0x100.
    select(1);
    do_reset();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(3, -1, 0);
    e = wr_log[log0];
    chk("gap_w0", e[31:0], 32'h11223344);
    chk("gap_a0", 32'(e[43:32]), 32'h100);
    e = wr_log[log0 + 1];
    chk("gap_w1", e[31:0], 32'h55667788);
    chk("gap_a1", 32'(e[43:32]), 32'h101);

    // Re-arm from DONE with a start pulse injected after 6 bytes.
    select(0);
    do_reset();
    fill_seq(80, 0);
    run_frame(1, -1, 0);
    fill_rand(80);
    run_frame(1, 6, 0);

    // Reset after 10 bytes, then a fresh frame.
    start_frame();
    fill_rand(80);
    run_bytes(10, 1, -1);
    do_reset();
    fill_rand(80);
    run_frame(1, -1, 0);
    e = wr_log[log0];
    chk("post_reset_w0", e[31:0], model_word(0));
    chk("post_reset_a0", 32'(e[43:32]), 0);

    // Single-word frames with good and bad checksum; start clears err.
    select(2);
    do_reset();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(1, -1, 0);
    run_frame(2, -1, 1);
    run_frame(1, -1, 0);

    // Random frames with random gaps on the two-word instance.
    select(1);
    do_reset();
    for (int r = 0; r < 6; r++) begin
      fill_rand(8);
      run_frame(int'($urandom_range(1, 4)), -1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/header_loader.md
Name: header_loader

Overview:
- Upstream feeder for the miner's 32-bit word RAM.
- Accepts a byte stream from the UART receiver and packs it big-endian into DATA_WIDTH-bit words.
- Writes WORDS consecutive words into RAM starting at BASE_ADDR, then flags done so the hashing control can start reading the block header.
- Default frame is one 80-byte Bitcoin header, which is 20 words.

Parameters:
- DATA_WIDTH, 32, RAM word width. Must be a multiple of 8. BPW = DATA_WIDTH/8 bytes per word.
- ADDRESS_WIDTH, 12, RAM address width.
- BASE_ADDR, 0, first RAM address written.
- WORDS, 20, words per frame. Range 1..2^ADDRESS_WIDTH-BASE_ADDR.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; arms a new frame load.
- byte_in  in  8  received byte.
- byte_valid  in  1  byte_in valid this cycle.
- byte_ready  out  1  block accepts a byte this cycle; transfer = byte_valid & byte_ready.
- ram_wEn  out  1  RAM write enable; drives wEn.
- ram_addr  out  ADDRESS_WIDTH  RAM address.
- ram_data  out  DATA_WIDTH  RAM write data; drives dataIn.
- busy  out  1  frame load in progress.
- done  out  1  frame fully written; sticky.
- err  out  1  checksum mismatch (CHECKSUM_EN only; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: byte_ready=0, ram_wEn=0, ram_addr=BASE_ADDR, ram_data=0, busy=0, done=0, err=0. State=IDLE, byte and word counters cleared.
- States: IDLE, RECV, WRITE, CHECK (CHECKSUM_EN only), DONE.
- IDLE:
  - byte_ready=0.
  - start -> RECV. Clears word_idx, byte_idx, pack register, done, err. busy=1 from the next cycle.
- RECV:
  - byte_ready=1.
  - Each transfer shifts byte_in into the pack register; the first byte of a word lands in [DATA_WIDTH-1:DATA_WIDTH-8].
  - byte_idx counts 0..BPW-1. The transfer at byte_idx==BPW-1 moves the state to WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, ram_wEn=1, ram_addr=BASE_ADDR+word_idx, ram_data=packed word.
  - RAM captures on the falling clk edge inside this cycle. Address and data are driven from posedge, so they are stable half a cycle before capture.
  - Next state: if word_idx==WORDS-1, go to CHECK (if enabled) or DONE; otherwise word_idx++ and go to RECV.
- DONE:
  - busy=0, done=1, byte_ready=0.
  - Holds until start, which re-arms as from IDLE, or until reset.
- Latency: the last byte of a word is accepted at edge N; ram_wEn is high in cycle N+1 and the RAM commits mid-cycle N+1.
- Throughput: at most BPW bytes per BPW+1 cycles.
- Outside WRITE: ram_wEn=0 always. ram_addr and ram_data hold their last values.
- start while busy: ignored. The frame continues unaffected.
- byte_valid while byte_ready=0: byte is not consumed. The upstream holds it or drops it per its own protocol.
- reset mid-frame: on the next posedge everything returns to reset values and the partial word is discarded. Words already written stay in RAM.
- Address arithmetic: BASE_ADDR+word_idx, computed in ADDRESS_WIDTH bits. The WORDS range constraint guarantees no wrap.

Optional Feature:
- Macro: HEADER_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all frame bytes is kept.
  - After the last WRITE the block enters CHECK with byte_ready=1 and waits for one more byte.
  - On that transfer: err = (byte_in != xor_acc). Then go to DONE; done is asserted regardless of err.
  - err is sticky until start or reset. The checksum byte is not written to RAM.
- Undefined:
  - No CHECK state and no XOR register. err is tied to 0.

Decomposition:
- Shared package miner_pkg:
  - State encoding localparams: IDLE=0, RECV=1, WRITE=2, CHECK=3, DONE=4, 3-bit.
  - HEADER_BYTES=80 and HEADER_WORDS=20 constants, reused by the downstream reader.
- Sub-module byte_packer:
  - Shift register plus byte_idx counter.
  - Outputs word_full and word.
  - Parameterised by DATA_WIDTH.
- The FSM and address generation stay in header_loader.

Test Plan:
- Reset then start, then stream bytes 00..4F with byte_valid held high -> 20 WRITE pulses; addr 0..19; first word 0x00010203, last word 0x4C4D4E4F; done=1 one cycle after the 20th write; busy=0.
- Gapped stream (byte_valid high 1 of every 3 cycles), WORDS=2, BASE_ADDR=0x100 -> writes 0x11223344@0x100 and 0x55667788@0x101. ram_wEn is never high outside those two cycles.
- start pulsed mid-frame after 6 bytes -> ignored; the frame completes with the correct data and addresses.
- reset asserted after 10 bytes, then start and a full frame -> the first write goes to BASE_ADDR with new data; no stale bytes appear in word 0.
- With HEADER_LOADER_CHECKSUM_EN, frame 01 02 03 04 plus checksum 04, WORDS=1 -> done=1, err=0. Checksum 05 -> done=1, err=1. A following start clears err.
- Byte presented during the WRITE cycle (byte_ready=0) and held one more cycle -> consumed exactly once, as byte 0 of the next word.
